// File: rtl/cu_channel_retime_control_if.sv
`default_nettype none
// Command/response/almost-full bundle between the CU cluster and the CAPI buffer arbiters.
// Signal directions are named from the retime shell's point of view (slave modport).
interface cu_channel_retime_control_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int CMD_W        = 128,
  parameter int RSP_W        = 32
);
  logic [NUM_CHANNELS-1:0]       cmd_valid_in;
  logic [NUM_CHANNELS*CMD_W-1:0] cmd_payload_in;
  logic [NUM_CHANNELS-1:0]       cmd_valid_out;
  logic [NUM_CHANNELS*CMD_W-1:0] cmd_payload_out;
  logic [NUM_CHANNELS-1:0]       rsp_valid_in;
  logic [NUM_CHANNELS*RSP_W-1:0] rsp_payload_in;
  logic [NUM_CHANNELS-1:0]       rsp_valid_out;
  logic [NUM_CHANNELS*RSP_W-1:0] rsp_payload_out;
  logic [NUM_CHANNELS-1:0]       buf_full_in;
  logic [NUM_CHANNELS-1:0]       buf_full_out;

  modport master (
    output cmd_valid_in, cmd_payload_in, rsp_valid_in, rsp_payload_in, buf_full_in,
    input  cmd_valid_out, cmd_payload_out, rsp_valid_out, rsp_payload_out, buf_full_out
  );

  modport slave (
    input  cmd_valid_in, cmd_payload_in, rsp_valid_in, rsp_payload_in, buf_full_in,
    output cmd_valid_out, cmd_payload_out, rsp_valid_out, rsp_payload_out, buf_full_out
  );
endinterface
`default_nettype wire

// File: rtl/cu_channel_retime_control.sv
`default_nettype none
// cu_channel_retime_control: PIPE_DEPTH-stage retiming shell with outstanding tracking and RUN/DRAIN/IDLE quiesce.
// Optional macro CU_CHANNEL_RETIME_PERF_EN adds an issued-command counter on status_out[63:32].
module cu_channel_retime_control #(
  parameter int NUM_CHANNELS    = 4,
  parameter int PIPE_DEPTH      = 1,
  parameter int CMD_W           = 128,
  parameter int RSP_W           = 32,
  parameter int MAX_OUTSTANDING = 255
) (
  input  wire logic                   clock,
  input  wire logic                   rstn_in,
  input  wire logic                   enabled_in,
  cu_channel_retime_control_if.slave  bus,
  input  wire logic                   cu_done_in,
  output logic                        cu_done_out,
  output logic                        quiesced_out,
  output logic [63:0]                 status_out
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [15:0] popcnt(input logic [NUM_CHANNELS-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) c = c + {15'd0, v[i]};
    return c;
  endfunction

  // Reset asserts asynchronously and releases two clocks later, synchronous to clock.
  logic [1:0] r_rstn_sync;
  logic       w_rstn_internal;

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) r_rstn_sync <= 2'b00;
    else          r_rstn_sync <= {r_rstn_sync[0], 1'b1};
  end

  assign w_rstn_internal = r_rstn_sync[1];

  state_t r_state;
  logic   r_en_q;
  logic   r_cu_done;
  logic   r_quiesced;

  logic [NUM_CHANNELS-1:0]       r_cmd_v [PIPE_DEPTH];
  logic [NUM_CHANNELS*CMD_W-1:0] r_cmd_p [PIPE_DEPTH];
  logic [NUM_CHANNELS-1:0]       r_rsp_v [PIPE_DEPTH];
  logic [NUM_CHANNELS*RSP_W-1:0] r_rsp_p [PIPE_DEPTH];
  logic [NUM_CHANNELS-1:0]       r_full  [PIPE_DEPTH];

  logic [CNT_W-1:0] r_cnt [NUM_CHANNELS];
  logic             r_underflow;
  logic             r_overflow;
  logic [15:0]      r_drop_cnt;

  logic [NUM_CHANNELS-1:0] w_cmd_capture;
  logic [NUM_CHANNELS-1:0] w_cmd_drop;
  logic [NUM_CHANNELS-1:0] w_cmd_out;
  logic [NUM_CHANNELS-1:0] w_pipe_any;
  logic                    w_pipe_empty;
  logic                    w_cnt_zero;
  logic [16:0]             w_drop_sum;
  logic [7:0]              w_cnt0_byte;
  logic [31:0]             w_perf_word;

  assign w_cmd_capture = bus.cmd_valid_in & {NUM_CHANNELS{r_state == RUN}};
  assign w_cmd_drop    = bus.cmd_valid_in & ~w_cmd_capture;
  assign w_cmd_out     = r_cmd_v[PIPE_DEPTH-1];

  always_comb begin
    w_pipe_any = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) w_pipe_any = w_pipe_any | r_cmd_v[k];
  end

  assign w_pipe_empty = ~|w_pipe_any;

  always_comb begin
    w_cnt_zero = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_cnt[i] != '0) w_cnt_zero = 1'b0;
    end
  end

  // Command, response and almost-full pipes share the same depth so they stay aligned.
  always_ff @(posedge clock or negedge w_rstn_internal) begin
    if (!w_rstn_internal) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_cmd_v[k] <= '0;
        r_cmd_p[k] <= '0;
        r_rsp_v[k] <= '0;
        r_rsp_p[k] <= '0;
        r_full[k]  <= '1;
      end
    end else begin
      r_cmd_v[0] <= w_cmd_capture;
      r_cmd_p[0] <= bus.cmd_payload_in;
      r_rsp_v[0] <= bus.rsp_valid_in;
      r_rsp_p[0] <= bus.rsp_payload_in;
      r_full[0]  <= bus.buf_full_in;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_cmd_v[k] <= r_cmd_v[k-1];
        r_cmd_p[k] <= r_cmd_p[k-1];
        r_rsp_v[k] <= r_rsp_v[k-1];
        r_rsp_p[k] <= r_rsp_p[k-1];
        r_full[k]  <= r_full[k-1];
      end
    end
  end

  assign bus.cmd_valid_out   = r_cmd_v[PIPE_DEPTH-1];
  assign bus.cmd_payload_out = r_cmd_p[PIPE_DEPTH-1];
  assign bus.rsp_valid_out   = r_rsp_v[PIPE_DEPTH-1];
  assign bus.rsp_payload_out = r_rsp_p[PIPE_DEPTH-1];
  assign bus.buf_full_out    = r_full[PIPE_DEPTH-1];

  // A command leaving the pipe and a response arriving in the same cycle cancel out.
  always_ff @(posedge clock or negedge w_rstn_internal) begin
    if (!w_rstn_internal) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_cnt[i] <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_cmd_out[i] && !bus.rsp_valid_in[i]) begin
          if (r_cnt[i] == CNT_MAX) r_overflow <= 1'b1;
          else                     r_cnt[i]   <= r_cnt[i] + CNT_ONE;
        end else if (bus.rsp_valid_in[i] && !w_cmd_out[i]) begin
          if (r_cnt[i] == '0) r_underflow <= 1'b1;
          else                r_cnt[i]    <= r_cnt[i] - CNT_ONE;
        end
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, popcnt(w_cmd_drop)};

  always_ff @(posedge clock or negedge w_rstn_internal) begin
    if (!w_rstn_internal) r_drop_cnt <= '0;
    else                  r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  always_ff @(posedge clock or negedge w_rstn_internal) begin
    if (!w_rstn_internal) begin
      r_en_q     <= 1'b0;
      r_state    <= IDLE;
      r_cu_done  <= 1'b0;
      r_quiesced <= 1'b1;
    end else begin
      r_en_q <= enabled_in;
      case (r_state)
        IDLE:    if (r_en_q) r_state <= RUN;
        RUN:     if (!r_en_q) r_state <= DRAIN;
        DRAIN: begin
          if (r_en_q)                          r_state <= RUN;
          else if (w_pipe_empty && w_cnt_zero) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      r_cu_done  <= cu_done_in && (r_state != IDLE) && w_pipe_empty && w_cnt_zero;
      r_quiesced <= (r_state == IDLE);
    end
  end

  assign cu_done_out  = r_cu_done;
  assign quiesced_out = r_quiesced;

  if (CNT_W >= 8) begin : g_cnt0_trunc
    assign w_cnt0_byte = r_cnt[0][7:0];
  end else begin : g_cnt0_zext
    assign w_cnt0_byte = {{(8-CNT_W){1'b0}}, r_cnt[0]};
  end

`ifdef CU_CHANNEL_RETIME_PERF_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clock or negedge w_rstn_internal) begin
    if (!w_rstn_internal) r_perf_cnt <= '0;
    else                  r_perf_cnt <= r_perf_cnt + {16'd0, popcnt(w_cmd_out)};
  end

  assign w_perf_word = r_perf_cnt;
`else
  assign w_perf_word = 32'd0;
`endif

  assign status_out = {w_perf_word, r_drop_cnt, w_cnt0_byte, 4'b0000,
                       r_overflow, r_underflow, r_state};

endmodule
`default_nettype wire

// File: tb/tb_cu_channel_retime_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_channel_retime_control
// Brief    : Directed bench, PIPE_DEPTH=2, MAX_OUTSTANDING=15, hand-computed
//            expectations.
// Revision : 1.1
// ============================================================================
module tb_cu_channel_retime_control;

    logic        clock;
    logic        rstn_in;
    logic        enabled_in;
    logic        cu_done_in;
    logic        cu_done_out;
    logic        quiesced_out;
    logic [63:0] status_out;
    int          n_vec;
    int          n_err;
    logic [31:0] exp_perf;

    cu_channel_retime_control_if #(.NUM_CHANNELS(4), .CMD_W(128), .RSP_W(32)) bus ();

    cu_channel_retime_control #(
        .NUM_CHANNELS(4), .PIPE_DEPTH(2), .CMD_W(128), .RSP_W(32), .MAX_OUTSTANDING(15)
    ) dut (
        .clock        (clock),
        .rstn_in      (rstn_in),
        .enabled_in   (enabled_in),
        .bus          (bus),
        .cu_done_in   (cu_done_in),
        .cu_done_out  (cu_done_out),
        .quiesced_out (quiesced_out),
        .status_out   (status_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn_in = 1'b0;
        enabled_in = 1'b0;
        cu_done_in = 1'b0;
        bus.cmd_valid_in = '0;
        bus.cmd_payload_in = '0;
        bus.rsp_valid_in = '0;
        bus.rsp_payload_in = '0;
        bus.buf_full_in = '0;
        repeat (3) tick();

        check("rst_cmd_v", bus.cmd_valid_out, 4'b0000);
        check("rst_rsp_v", bus.rsp_valid_out, 4'b0000);
        check("rst_cmd_p", bus.cmd_payload_out, 512'd0);
        check("rst_full", bus.buf_full_out, 4'hF);
        check("rst_quiesced", quiesced_out, 1'b1);
        check("rst_done", cu_done_out, 1'b0);
        check("rst_status", status_out, 64'd0);

        // Release: sync flops at E1/E2, en_q at E3, RUN at E4.
        rstn_in = 1'b1;
        enabled_in = 1'b1;
        repeat (3) tick();
        check("idle_after_sync", status_out[1:0], 2'd0);
        tick();
        check("run_state", status_out[1:0], 2'd1);
        check("quiesced_e4", quiesced_out, 1'b1);

        // Single command on ch0, latency 2.
        bus.cmd_valid_in = 4'b0001;
        bus.cmd_payload_in[127:0] = 128'hABCD;
        tick();
        bus.cmd_valid_in = 4'b0000;
        check("cmd_lat1", bus.cmd_valid_out, 4'b0000);
        check("quiesced_run", quiesced_out, 1'b0);
        tick();
        check("cmd_lat2_v", bus.cmd_valid_out, 4'b0001);
        check("cmd_lat2_p", bus.cmd_payload_out[127:0], 128'hABCD);
        tick();
        check("cnt_after_1", status_out[15:8], 8'd1);
        check("cmd_v_gone", bus.cmd_valid_out, 4'b0000);

        // Two more commands on ch0 -> counter 3.
        bus.cmd_valid_in = 4'b0001;
        repeat (2) tick();
        bus.cmd_valid_in = 4'b0000;
        repeat (2) tick();
        check("cnt_3", status_out[15:8], 8'd3);

        // Command out and response in on the same cycle.
        bus.cmd_valid_in = 4'b0001;
        tick();
        bus.cmd_valid_in = 4'b0000;
        tick();
        bus.rsp_valid_in = 4'b0001;
        bus.rsp_payload_in[31:0] = 32'h1234_5678;
        bus.buf_full_in = 4'b1010;
        tick();
        bus.rsp_valid_in = 4'b0000;
        check("cnt_same_cycle", status_out[15:8], 8'd3);
        check("rsp_lat1", bus.rsp_valid_out, 4'b0000);
        tick();
        check("rsp_lat2_v", bus.rsp_valid_out, 4'b0001);
        check("rsp_lat2_p", bus.rsp_payload_out[31:0], 32'h1234_5678);
        check("full_retimed", bus.buf_full_out, 4'b1010);
        check("cnt_still_3", status_out[15:8], 8'd3);

        // Down to 2 outstanding, then disable -> DRAIN.
        bus.rsp_valid_in = 4'b0001;
        tick();
        bus.rsp_valid_in = 4'b0000;
        enabled_in = 1'b0;
        repeat (2) tick();
        check("drain_state", status_out[1:0], 2'd2);
        bus.cmd_valid_in = 4'b0110;
        tick();
        bus.cmd_valid_in = 4'b0000;
        check("drop_cnt", status_out[31:16], 16'd2);
        tick();
        check("drain_no_cmd", bus.cmd_valid_out, 4'b0000);

        // Done qualification while draining the last responses.
        cu_done_in = 1'b1;
        bus.rsp_valid_in = 4'b0001;
        tick();
        bus.rsp_valid_in = 4'b0000;
        check("done_cnt2", cu_done_out, 1'b0);
        tick();
        check("done_cnt1", cu_done_out, 1'b0);
        check("cnt_1", status_out[15:8], 8'd1);
        bus.rsp_valid_in = 4'b0001;
        tick();
        bus.rsp_valid_in = 4'b0000;
        check("done_lag", cu_done_out, 1'b0);
        check("still_drain", status_out[1:0], 2'd2);
        tick();
        check("done_high", cu_done_out, 1'b1);
        check("idle_state", status_out[1:0], 2'd0);
        check("quiesced_lag", quiesced_out, 1'b0);
        tick();
        check("quiesced_idle", quiesced_out, 1'b1);
        check("done_idle", cu_done_out, 1'b0);

        // Underflow on ch0.
        cu_done_in = 1'b0;
        bus.rsp_valid_in = 4'b0001;
        tick();
        bus.rsp_valid_in = 4'b0000;
        check("underflow", status_out[2], 1'b1);
        check("cnt_hold0", status_out[15:8], 8'd0);
        check("no_overflow", status_out[3], 1'b0);

        // Re-enable; all 4 channels issue 10 commands each.
        enabled_in = 1'b1;
        repeat (2) tick();
        check("rerun_state", status_out[1:0], 2'd1);
        bus.cmd_valid_in = 4'hF;
        repeat (10) tick();
        bus.cmd_valid_in = 4'b0000;
        repeat (4) tick();
`ifdef CU_CHANNEL_RETIME_PERF_EN
        exp_perf = 32'd44;
`else
        exp_perf = 32'd0;
`endif
        check("perf_40", status_out[63:32], exp_perf);
        check("cnt_10", status_out[15:8], 8'd10);

        // Ch1 from 10 pushed past the limit of 15.
        bus.cmd_valid_in = 4'b0010;
        repeat (6) tick();
        bus.cmd_valid_in = 4'b0000;
        repeat (4) tick();
`ifdef CU_CHANNEL_RETIME_PERF_EN
        exp_perf = 32'd50;
`endif
        check("overflow", status_out[3], 1'b1);
        check("underflow_sticky", status_out[2], 1'b1);
        check("perf_50", status_out[63:32], exp_perf);

        // Asynchronous reset with traffic in flight.
        bus.cmd_valid_in = 4'hF;
        repeat (2) tick();
        check("pre_reset_cmd_v", bus.cmd_valid_out, 4'hF);
        rstn_in = 1'b0;
        #1;
        check("mid_rst_cmd_v", bus.cmd_valid_out, 4'b0000);
        check("mid_rst_cmd_p", bus.cmd_payload_out, 512'd0);
        check("mid_rst_full", bus.buf_full_out, 4'hF);
        check("mid_rst_quiesced", quiesced_out, 1'b1);
        check("mid_rst_status", status_out, 64'd0);
        bus.cmd_valid_in = 4'b0000;
        enabled_in = 1'b0;
        tick();
        rstn_in = 1'b1;
        repeat (4) tick();
        check("post_rst_status", status_out, 64'd0);
        check("post_rst_quiesced", quiesced_out, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cu_channel_retime_control.md
Name: cu_channel_retime_control

Overview:
- Parametrised retiming and enable/quiesce shell between the CU cluster and the CAPI buffer arbiters.
- Generalises the fixed four-channel, single-stage latch wrapper to NUM_CHANNELS command/response channels with PIPE_DEPTH register stages per direction.
- Adds per-channel outstanding-command tracking, a RUN/DRAIN/IDLE quiesce state machine, and a `cu_done_out` that is qualified by drained traffic.

Parameters:
- NUM_CHANNELS, 4, number of independent command/response channels (read, prefetch-read, prefetch-write, write).
- PIPE_DEPTH, 1, register stages on the command path and on the response path; legal range 1..4.
- CMD_W, 128, command payload width per channel.
- RSP_W, 32, response payload width per channel.
- MAX_OUTSTANDING, 255, per-channel outstanding command limit; counter width CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clock  in  1  clock
- rstn_in  in  1  reset
- enabled_in  in  1  global enable from the AFU control
- cmd_valid_in  in  NUM_CHANNELS  CU command valid, one bit per channel
- cmd_payload_in  in  NUM_CHANNELS*CMD_W  CU command payload; channel i occupies slice [i*CMD_W +: CMD_W]
- cmd_valid_out  out  NUM_CHANNELS  command valid toward the buffers
- cmd_payload_out  out  NUM_CHANNELS*CMD_W  retimed command payload
- rsp_valid_in  in  NUM_CHANNELS  buffer response valid
- rsp_payload_in  in  NUM_CHANNELS*RSP_W  response payload
- rsp_valid_out  out  NUM_CHANNELS  response valid toward the CU
- rsp_payload_out  out  NUM_CHANNELS*RSP_W  retimed response payload
- buf_full_in  in  NUM_CHANNELS  buffer almost-full status
- buf_full_out  out  NUM_CHANNELS  retimed almost-full status toward the CU
- cu_done_in  in  1  CU cluster done
- cu_done_out  out  1  qualified done
- quiesced_out  out  1  1 when in IDLE with no traffic in flight
- status_out  out  64  status word

Behaviour:

Reset:
- `rstn_in` is asynchronous and active-low; `clock` is the block clock.
- Internal reset `rstn_internal` is asserted asynchronously and released through 2 flops; all other flops reset on `rstn_internal`.
- Reset values: `cmd_valid_out`, `rsp_valid_out`, all payloads, `cu_done_out` and `status_out` = 0; `buf_full_out` = all 1s; `quiesced_out` = 1.
- Enable register `en_q` <= `enabled_in`, resets to 0.

State machine (2-bit `state`; IDLE=0, RUN=1, DRAIN=2):
- IDLE -> RUN when `en_q`=1.
- RUN -> DRAIN when `en_q`=0.
- DRAIN -> RUN when `en_q`=1 (takes priority).
- DRAIN -> IDLE when the command pipe holds no valids and all outstanding counters are 0.

Command path:
- Stage 0 captures `cmd_valid_in & {NUM_CHANNELS{state==RUN}}`. Commands presented outside RUN are dropped and counted in `drop_cnt` (16-bit, saturating).
- Valids shift every cycle. `cmd_valid_out` appears exactly PIPE_DEPTH cycles after capture. Payload shifts alongside its valid.

Response path:
- Ungated in every state.
- Latency PIPE_DEPTH.
- `buf_full_in` is retimed with the same latency.

Outstanding counters (per channel):
- +1 on `cmd_valid_out[i]`; -1 on `rsp_valid_in[i]`; no change when both occur in the same cycle.
- Decrement at 0: counter holds 0 and sticky `underflow` is set.
- Increment at MAX_OUTSTANDING: counter holds its value and sticky `overflow` is set.
- Sticky bits clear only on reset.

`cu_done_out`:
- Registered: `cu_done_in` AND (state != IDLE) AND command pipe empty AND all counters 0.
- Drops to 0 the cycle after any term is false.

`quiesced_out`:
- Registered (state==IDLE).

`status_out` bit map:
- [1:0] state
- [2] underflow
- [3] overflow
- [15:8] channel-0 counter: low 8 bits if CNT_W > 8, zero-extended if CNT_W < 8
- [31:16] `drop_cnt`
- [63:32] per the optional feature

Optional Feature:
- Macro: CU_CHANNEL_RETIME_PERF_EN.
- Enabled: a 32-bit wrapping counter of total commands issued (popcount of `cmd_valid_out` per cycle) drives `status_out[63:32]`; it resets to 0 and counts in all states.
- Disabled: `status_out[63:32]` is tied to 0 and no counter logic exists.

Test Plan:
- Reset with `rstn_in`=0 mid-traffic, then release -> all outputs at reset values; `buf_full_out`=4'hF; `quiesced_out`=1; first capture possible no earlier than 3 cycles after release plus 1 enable cycle.
- PIPE_DEPTH=2, `en_q`=1, `cmd_valid_in`=4'b0001 with payload 0xABCD for one cycle -> `cmd_valid_out[0]`=1 with payload 0xABCD exactly 2 cycles later; `status_out[15:8]`=1.
- Response and command on channel 0 in the same cycle with counter=3 -> counter stays 3. Response with counter=0 -> counter stays 0 and `status_out[2]`=1.
- Drop `enabled_in` with 2 commands outstanding -> state=DRAIN (`status_out[1:0]`=2). Commands presented during DRAIN leave `cmd_valid_out` = 0 and increment `drop_cnt`. After 2 responses -> IDLE and `quiesced_out`=1 one cycle later.
- `cu_done_in`=1 with 1 outstanding -> `cu_done_out`=0; after the final response -> `cu_done_out`=1 next cycle.
- With CU_CHANNEL_RETIME_PERF_EN, 4 channels each issue 10 commands -> `status_out[63:32]`=40; without the macro -> 0.
